// File: rtl/mbist_resp_if.sv
// Signal bundle between the MBIST sequencer/memory (master) and the response
// comparator (slave).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

interface mbist_resp_if #(
   parameter int dw = `DATA_WIDTH,
   parameter int aw = `ADDR_WIDTH,
   parameter int cw = 16
);
   logic          start;
   logic          stop;
   logic          rd_issue;
   logic [aw-1:0] rd_addr;
   logic [dw-1:0] exp_data;
   logic [dw-1:0] cmp_mask;
   logic [dw-1:0] mem_data;
   logic          busy;
   logic          done;
   logic          pass;
   logic          fail_pulse;
   logic          fail_sticky;
   logic [cw-1:0] fail_count;
   logic [aw-1:0] ff_addr;
   logic [dw-1:0] ff_exp;
   logic [dw-1:0] ff_act;

   modport master (
      output start, stop, rd_issue, rd_addr, exp_data, cmp_mask, mem_data,
      input  busy, done, pass, fail_pulse, fail_sticky, fail_count,
             ff_addr, ff_exp, ff_act
   );

   modport slave (
      input  start, stop, rd_issue, rd_addr, exp_data, cmp_mask, mem_data,
      output busy, done, pass, fail_pulse, fail_sticky, fail_count,
             ff_addr, ff_exp, ff_act
   );
endinterface

// File: rtl/mbist_resp_compare.sv
// MBIST response comparator: delays each issued read by the memory latency,
// compares it against memory data under a mask and logs fail statistics.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

// state   | meaning
// S_IDLE  | out of reset, waiting for start
// S_RUN   | accepting reads from the sequencer
// S_DRAIN | sequencer finished, comparing reads still in flight
// S_DONE  | results valid, waiting for the next start
module mbist_resp_compare #(
   parameter int dw     = `DATA_WIDTH,
   parameter int aw     = `ADDR_WIDTH,
   parameter int rd_lat = 1,
   parameter int cw     = 16
) (
   input  logic        clk,
   input  logic        rst,
   mbist_resp_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [rd_lat-1:0] r_vld;
   logic [aw-1:0] r_addr [rd_lat];
   logic [dw-1:0] r_exp  [rd_lat];
   logic [dw-1:0] r_mask [rd_lat];
   logic          r_done;
   logic          r_sticky;
   logic [cw-1:0] r_cnt;
   logic [aw-1:0] r_ff_addr;
   logic [dw-1:0] r_ff_exp;
   logic [dw-1:0] r_ff_act;

   logic          w_start_ok;
   logic          w_capture;
   logic          w_detect;
   logic          w_inflight;

   always_comb begin
      w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
      w_capture  = bus.rd_issue && (r_state == S_RUN);
      w_detect   = r_vld[rd_lat-1] &&
                   (((bus.mem_data ^ r_exp[rd_lat-1]) & r_mask[rd_lat-1]) != '0);
      // The emerging stage is compared in the last DRAIN cycle, so only the
      // stages behind it keep DRAIN alive.
      w_inflight = 1'b0;
      for (int i = 0; i < rd_lat - 1; i++) begin
         w_inflight = w_inflight | r_vld[i];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (bus.stop) w_state_nxt = S_DRAIN;
         S_DRAIN: if (!w_inflight) w_state_nxt = S_DONE;
         S_DONE:  if (bus.start) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == S_DRAIN) && (w_state_nxt == S_DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else if (w_start_ok) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_capture;
         for (int i = 1; i < rd_lat; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // Payload needs no reset: it is only looked at alongside its valid bit.
   always_ff @(posedge clk) begin
      r_addr[0] <= bus.rd_addr;
      r_exp[0]  <= bus.exp_data;
      r_mask[0] <= bus.cmp_mask;
      for (int i = 1; i < rd_lat; i++) begin
         r_addr[i] <= r_addr[i-1];
         r_exp[i]  <= r_exp[i-1];
         r_mask[i] <= r_mask[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky  <= 1'b0;
         r_cnt     <= '0;
         r_ff_addr <= '0;
         r_ff_exp  <= '0;
         r_ff_act  <= '0;
      end else if (w_start_ok) begin
         r_sticky  <= 1'b0;
         r_cnt     <= '0;
         r_ff_addr <= '0;
         r_ff_exp  <= '0;
         r_ff_act  <= '0;
      end else if (w_detect) begin
         r_sticky <= 1'b1;
         if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         if (!r_sticky) begin
            r_ff_addr <= r_addr[rd_lat-1];
            r_ff_exp  <= r_exp[rd_lat-1];
            r_ff_act  <= bus.mem_data;
         end
      end
   end

   assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign bus.done        = r_done;
   assign bus.pass        = (r_state == S_DONE) && !r_sticky;
   assign bus.fail_pulse  = w_detect;
   assign bus.fail_sticky = r_sticky;
   assign bus.fail_count  = r_cnt;
   assign bus.ff_addr     = r_ff_addr;
   assign bus.ff_exp      = r_ff_exp;
   assign bus.ff_act      = r_ff_act;

endmodule

// File: tb/tb_mbist_resp_compare.sv
// Bench for mbist_resp_compare: three instances (latency 1, latency 3, and a
// 4-bit counter) share one stimulus stream and are checked against a model.
`timescale 1ns/1ps

`define DRV(IFN, MEM) \
   assign IFN.start = start; assign IFN.stop = stop; assign IFN.rd_issue = rd_issue; \
   assign IFN.rd_addr = rd_addr; assign IFN.exp_data = exp_data; \
   assign IFN.cmp_mask = cmp_mask; assign IFN.mem_data = MEM;

`define OBS(K, IFN) \
   assign o_busy[K] = 32'(IFN.busy); assign o_done[K] = 32'(IFN.done); \
   assign o_pass[K] = 32'(IFN.pass); assign o_fp[K] = 32'(IFN.fail_pulse); \
   assign o_st[K] = 32'(IFN.fail_sticky); assign o_cnt[K] = 32'(IFN.fail_count); \
   assign o_ffa[K] = 32'(IFN.ff_addr); assign o_ffe[K] = 32'(IFN.ff_exp); \
   assign o_ffx[K] = 32'(IFN.ff_act);

module tb_mbist_resp_compare;
   localparam int DW = 8;
   localparam int AW = 8;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] exp;
      logic [7:0] mask;
      logic [7:0] act;
   } tx_t;

   logic clk = 1'b0;
   logic rst;
   logic start, stop, rd_issue;
   logic [7:0] rd_addr, exp_data, cmp_mask, act;
   logic [7:0] act_d1, act_d2, act_d3;

   always #5 clk = ~clk;

   // memory model: the word returned k cycles after issue is act_dk
   always @(posedge clk) begin
      act_d1 <= act;
      act_d2 <= act_d1;
      act_d3 <= act_d2;
   end

   mbist_resp_if #(.dw(DW), .aw(AW), .cw(16)) if_a ();
   mbist_resp_if #(.dw(DW), .aw(AW), .cw(16)) if_b ();
   mbist_resp_if #(.dw(DW), .aw(AW), .cw(4))  if_c ();

   `DRV(if_a, act_d1)
   `DRV(if_b, act_d3)
   `DRV(if_c, act_d1)

   mbist_resp_compare #(.dw(DW), .aw(AW), .rd_lat(1), .cw(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   mbist_resp_compare #(.dw(DW), .aw(AW), .rd_lat(3), .cw(16)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   mbist_resp_compare #(.dw(DW), .aw(AW), .rd_lat(1), .cw(4))  u_c (.clk(clk), .rst(rst), .bus(if_c));

   logic [31:0] o_busy [3], o_done [3], o_pass [3], o_fp [3], o_st [3];
   logic [31:0] o_cnt [3], o_ffa [3], o_ffe [3], o_ffx [3];

   `OBS(0, if_a)
   `OBS(1, if_b)
   `OBS(2, if_c)

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   bit  running = 0;
   bit  miss_age [1:3];
   tx_t txq [$];
   int  stop_cyc = 0;
   int  last_iss_cyc = 0;
   int  done_cyc [3];
   int  done_n [3];

   function automatic int lat(int k);
      return (k == 1) ? 3 : 1;
   endfunction

   function automatic int cwk(int k);
      return (k == 2) ? 4 : 16;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic clear_model();
      running = 0;
      txq.delete();
      for (int i = 1; i <= 3; i++) miss_age[i] = 0;
      for (int k = 0; k < 3; k++) begin
         done_n[k] = 0;
         done_cyc[k] = 0;
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, check on the negedge.
   task automatic do_cyc(input bit s, input bit p, input bit iss,
                         input logic [7:0] a, input logic [7:0] e,
                         input logic [7:0] m, input logic [7:0] x);
      bit acc;
      bit miss;
      start = s; stop = p; rd_issue = iss;
      rd_addr = a; exp_data = e; cmp_mask = m; act = x;
      @(posedge clk);
      cyc++;
      acc  = iss && running;
      miss = acc && (((e ^ x) & m) != 8'h00);
      if (acc) begin
         txq.push_back('{a, e, m, x});
         last_iss_cyc = cyc;
      end
      if (s && !running) begin
         clear_model();
         running = 1;
      end else if (p && running) begin
         running = 0;
         stop_cyc = cyc;
      end
      miss_age[3] = miss_age[2];
      miss_age[2] = miss_age[1];
      miss_age[1] = miss;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("fail_pulse", k, o_fp[k], 32'(miss_age[lat(k)]));
         if (o_done[k] == 32'd1) begin
            done_n[k]++;
            done_cyc[k] = cyc;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic start_run();
      do_cyc(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 3; k++) begin
         chk("busy_after_start", k, o_busy[k], 32'd1);
         chk("cnt_after_start", k, o_cnt[k], 32'd0);
         chk("sticky_after_start", k, o_st[k], 32'd0);
         chk("ffaddr_after_start", k, o_ffa[k], 32'd0);
         chk("pass_in_run", k, o_pass[k], 32'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_busy"}, k, o_busy[k], 32'd0);
         chk({tag, "_done"}, k, o_done[k], 32'd0);
         chk({tag, "_pass"}, k, o_pass[k], 32'd0);
         chk({tag, "_fp"}, k, o_fp[k], 32'd0);
         chk({tag, "_sticky"}, k, o_st[k], 32'd0);
         chk({tag, "_cnt"}, k, o_cnt[k], 32'd0);
         chk({tag, "_ffaddr"}, k, o_ffa[k], 32'd0);
         chk({tag, "_ffexp"}, k, o_ffe[k], 32'd0);
         chk({tag, "_ffact"}, k, o_ffx[k], 32'd0);
      end
   endtask

   // Wait (bounded) for every instance to finish, then check run results.
   task automatic finish_run(input string tag);
      int  fails;
      int  exp_cnt;
      int  exp_done;
      bit  have;
      tx_t ff;
      for (int i = 0; i < 16 && !(done_n[0] > 0 && done_n[1] > 0 && done_n[2] > 0); i++) idle(1);
      idle(1);
      fails = 0;
      have = 0;
      ff = '0;
      foreach (txq[i]) begin
         if (((txq[i].exp ^ txq[i].act) & txq[i].mask) != 8'h00) begin
            fails++;
            if (!have) begin
               ff = txq[i];
               have = 1;
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         exp_done = stop_cyc + 1;
         if (txq.size() > 0 && last_iss_cyc + lat(k) > exp_done) exp_done = last_iss_cyc + lat(k);
         exp_cnt = (fails > (1 << cwk(k)) - 1) ? (1 << cwk(k)) - 1 : fails;
         chk({tag, "_done_pulses"}, k, done_n[k], 32'd1);
         chk({tag, "_done_cycle"}, k, done_cyc[k], exp_done);
         chk({tag, "_busy"}, k, o_busy[k], 32'd0);
         chk({tag, "_pass"}, k, o_pass[k], 32'(fails == 0));
         chk({tag, "_sticky"}, k, o_st[k], 32'(fails != 0));
         chk({tag, "_count"}, k, o_cnt[k], exp_cnt);
         chk({tag, "_ffaddr"}, k, o_ffa[k], 32'(ff.addr));
         chk({tag, "_ffexp"}, k, o_ffe[k], 32'(ff.exp));
         chk({tag, "_ffact"}, k, o_ffx[k], 32'(ff.act));
      end
   endtask

   initial begin
      logic [7:0] one;
      logic [7:0] a, e, m, x;
      bit iss;
      one = 8'h01;
      rst = 1'b1;
      start = 0; stop = 0; rd_issue = 0;
      rd_addr = 0; exp_data = 0; cmp_mask = 0; act = 0;
      clear_model();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      idle(2);
      check_zero("idle");

      // clean run: 8 matching reads, last one with stop
      start_run();
      for (int i = 0; i < 8; i++) begin
         e = 8'($urandom);
         do_cyc(0, i == 7, 1, 8'(i), e, 8'hFF, e);
      end
      finish_run("clean");

      // single fail at addr 5
      start_run();
      do_cyc(0, 0, 1, 8'h04, 8'h11, 8'hFF, 8'h11);
      do_cyc(0, 1, 1, 8'h05, 8'hA5, 8'hFF, 8'hA4);
      finish_run("single");

      // first-fail retention: fails at addr 3 and 9
      start_run();
      for (int i = 0; i < 10; i++) begin
         e = 8'($urandom);
         x = (i == 3 || i == 9) ? (e ^ 8'h80) : e;
         do_cyc(0, i == 9, 1, 8'(i), e, 8'hFF, x);
      end
      finish_run("retain");

      // masking: masked-out bit difference passes, enabled bit fails
      start_run();
      do_cyc(0, 0, 1, 8'h20, 8'hFF, 8'hFE, 8'hFE);
      do_cyc(0, 0, 1, 8'h21, 8'hFF, 8'h00, 8'h00);
      do_cyc(0, 1, 1, 8'h22, 8'hFF, 8'h01, 8'hFE);
      finish_run("mask");

      // randomized run with an ignored mid-run start and idle gaps
      start_run();
      for (int i = 0; i < 40; i++) begin
         iss = ($urandom_range(0, 3) != 0);
         a = 8'($urandom);
         e = 8'($urandom);
         case ($urandom_range(0, 5))
            0: m = 8'h00;
            1: m = 8'hFF;
            default: m = 8'($urandom);
         endcase
         x = ($urandom_range(0, 2) == 0) ? (e ^ (one << $urandom_range(0, 7))) : e;
         do_cyc(i == 15, 0, iss, a, e, m, x);
      end
      do_cyc(0, 1, 1, 8'hEE, 8'h3C, 8'hFF, 8'hC3);
      finish_run("random");

      // stop with nothing in flight
      start_run();
      do_cyc(0, 0, 1, 8'h01, 8'h0F, 8'hFF, 8'h0E);
      idle(4);
      do_cyc(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      finish_run("empty_drain");

      // saturation: 20 consecutive fails
      start_run();
      for (int i = 0; i < 20; i++) begin
         do_cyc(0, i == 19, 1, 8'(i + 40), 8'(i), 8'hFF, ~8'(i));
      end
      finish_run("saturate");

      // reset mid-run aborts the run with no done
      start_run();
      for (int i = 0; i < 5; i++) do_cyc(0, 0, 1, 8'(i), 8'h55, 8'hFF, 8'h50);
      #2 rst = 1'b1;
      #1 check_zero("midrun_reset");
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      idle(6);
      for (int k = 0; k < 3; k++) begin
         chk("no_done_after_abort", k, done_n[k], 32'd0);
         chk("idle_after_abort", k, o_busy[k], 32'd0);
      end

      // restart after the abort still works
      start_run();
      do_cyc(0, 1, 1, 8'h07, 8'h12, 8'hFF, 8'h13);
      finish_run("after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
